recip_serial_unit: RTL
======================

RECIP_SERIAL_UNIT -- requirements
Module: recip_serial_unit

Interface
REQ-001 Parameter IW, default 4: input chunk width in bits.
REQ-002 Parameter QI, default 6: integer bits, including sign, of the signed fixed-point operand and result.
REQ-003 Parameter QF, default 10: fraction bits; W = QI+QF; W SHALL be a multiple of IW and OW; 2*QF >= W-1.
REQ-004 Parameter OW, default 8: output chunk width in bits.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 i_valid  input  1  input chunk present on i_data.
REQ-008 i_data  input  IW  operand chunk, MSB chunk first.
REQ-009 i_abs  input  1  1 = output magnitude of reciprocal; sampled with final input chunk.
REQ-010 o_ready  output  1  block accepts an input chunk this cycle.
REQ-011 o_valid  output  1  o_data holds a valid result chunk.
REQ-012 o_data  output  OW  result chunk, MSB chunk first.
REQ-013 i_ready  input  1  downstream accepts o_data this cycle.
REQ-014 o_last  output  1  current o_data is the final chunk of the result.
REQ-015 o_sat  output  1  current result saturated; valid whenever o_valid=1.
REQ-016 o_busy  output  1  high in DIVIDE and SEND states.

Function
REQ-017 FSM states: LOAD, DIVIDE, SEND; reset state LOAD.
REQ-018 LOAD: o_ready=1; each cycle with i_valid=1, operand <= {operand shifted left IW, i_data}; chunk counter increments.
REQ-019 On acceptance of chunk W/IW, capture i_abs, go to DIVIDE, clear counter.
REQ-020 DIVIDE: o_ready=0, o_valid=0; lasts exactly W cycles; first o_valid exactly W cycles after the edge accepting the final chunk.
REQ-021 Let m = |operand| as W-bit unsigned; q = floor(2^(2*QF) / m).
REQ-022 o_sat=1 iff m==0 or q > 2^(W-1)-1; result magnitude is then 2^(W-1)-1, else q.
REQ-023 Sign: if captured abs=0 and operand negative, result = two's complement negation of magnitude; else result = magnitude.
REQ-024 SEND: o_valid=1; o_data = result chunk k (k=0 is MSB chunk); k advances only on cycles with o_valid & i_ready.
REQ-025 While o_valid=1 and i_ready=0, o_data, o_last and o_sat SHALL hold stable.
REQ-026 o_last=1 only on chunk W/OW-1; its acceptance returns FSM to LOAD, with o_ready=1 on the next cycle.
REQ-027 i_valid outside LOAD is ignored; no input chunk is lost or duplicated in LOAD.
REQ-028 Operand register reset value SHALL be 0.

Reset
REQ-029 reset=1 at any state, including mid-LOAD, mid-DIVIDE and mid-SEND, SHALL discard all work on the next edge.
REQ-030 On that edge: state LOAD; counters and operand 0; o_valid=0, o_data=0, o_last=0, o_sat=0, o_busy=0; o_ready=1 the cycle after.

Structure
REQ-031 Package recip_pkg SHALL hold the FSM state enum, default parameter values and the saturation-magnitude function.
REQ-032 Iterative restoring divider in sub-module recip_div_iter: start/done, one quotient bit per cycle; top level holds the FSM, shift registers and sign logic.

Verification (defaults: W=16, Q6.10, 4 in-chunks, 2 out-chunks)
REQ-033 Load 0x0400 (1.0), abs=0 -> chunks 0x04, 0x00; o_last on second; o_sat=0; first o_valid 16 cycles after final load.
REQ-034 Load 0x0800 -> 0x0200; load 0x0021 (m=33) -> 0x7C1F, o_sat=0; load 0x0020 -> 0x7FFF, o_sat=1.
REQ-035 Load 0xFC00, abs=0 -> 0xFC00; same operand with abs=1 -> 0x0400; load 0x0000 -> 0x7FFF, o_sat=1.
REQ-036 Hold i_ready=0 for 5 cycles in SEND -> o_data/o_last stable, no chunk skipped; i_valid gaps during LOAD -> same result as contiguous.
REQ-037 Assert reset during DIVIDE and during SEND -> outputs zero next cycle, then 0x0400 loads correctly to 0x0400.
REQ-038 Back-to-back operands with i_ready=1 held high -> o_ready returns the cycle after o_last acceptance; both results correct.

Source files
------------

// File: rtl/recip_pkg.sv
// Shared definitions for the serial fixed-point reciprocal unit.
// Holds default geometry, the FSM state encoding and the saturation magnitude.
// No logic of its own; imported by the interface, divider and top level.
package recip_pkg;

    localparam int DEF_IW = 4;
    localparam int DEF_QI = 6;
    localparam int DEF_QF = 10;
    localparam int DEF_OW = 8;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_SEND   = 2'd2
    } state_e;

    // Largest positive value of a w-bit two's complement word.
    function automatic logic [63:0] sat_mag(input int w);
        sat_mag = (64'd1 << (w - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/recip_serial_unit_if.sv
// Chunked operand-in / result-out handshake bundle for the reciprocal unit.
// Pure wiring, no latency.
// Input side is valid/ready (o_ready), output side is valid/ready (i_ready).
import recip_pkg::*;

interface recip_serial_unit_if #(
    parameter int IW = DEF_IW,
    parameter int OW = DEF_OW
);
    logic          i_valid;
    logic [IW-1:0] i_data;
    logic          i_abs;
    logic          o_ready;
    logic          o_valid;
    logic [OW-1:0] o_data;
    logic          i_ready;
    logic          o_last;
    logic          o_sat;
    logic          o_busy;

    modport slave (
        input  i_valid, i_data, i_abs, i_ready,
        output o_ready, o_valid, o_data, o_last, o_sat, o_busy
    );

    modport master (
        output i_valid, i_data, i_abs, i_ready,
        input  o_ready, o_valid, o_data, o_last, o_sat, o_busy
    );
endinterface

// File: rtl/recip_div_iter.sv
// Restoring divider, one quotient bit per cycle, W-1 quotient bits.
// Latency: start edge loads, W-1 further edges iterate; done_o high in the last cycle.
// No backpressure: a new start_i simply restarts the computation.
import recip_pkg::*;

module recip_div_iter #(
    parameter int W = DEF_QI + DEF_QF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [W-1:0] divisor_i,
    input  logic [W-1:0] rem_init_i,
    input  logic [W-2:0] dividend_lo_i,
    output logic         done_o,
    output logic [W-2:0] quot_o
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  rem_q;
    logic [W-2:0]  lo_q;
    logic [W-1:0]  div_q;
    logic [W-2:0]  quot_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;

    logic [W:0]    rem_sh;
    logic          ge;
    logic [W-1:0]  rem_nxt;

    // One restoring step: bring in the next dividend bit and subtract if it fits.
    always_comb begin
        rem_sh  = {rem_q, lo_q[W-2]};
        ge      = (rem_sh >= {1'b0, div_q});
        rem_nxt = ge ? (rem_sh[W-1:0] - div_q) : rem_sh[W-1:0];
    end

    // Load on start, then iterate until the counter drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            lo_q   <= '0;
            div_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= rem_init_i;
            lo_q   <= dividend_lo_i;
            div_q  <= divisor_i;
            quot_q <= '0;
            cnt_q  <= CW'(W - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                rem_q  <= rem_nxt;
                lo_q   <= lo_q << 1;
                quot_q <= (quot_q << 1) | {{(W-2){1'b0}}, ge};
                cnt_q  <= cnt_q - 1'b1;
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done_o = busy_q && (cnt_q == '0);
    assign quot_o = quot_q;

endmodule

// File: rtl/recip_serial_unit.sv
// Serial signed fixed-point reciprocal: 2^(2*QF)/x with saturation and optional magnitude.
// Latency: first result chunk valid exactly W cycles after the final operand chunk is accepted.
// Input stalls outside LOAD (o_ready=0); result chunks hold stable while i_ready=0.
import recip_pkg::*;

module recip_serial_unit #(
    parameter int IW = DEF_IW,
    parameter int QI = DEF_QI,
    parameter int QF = DEF_QF,
    parameter int OW = DEF_OW
) (
    input  logic             clk,
    input  logic             reset,
    recip_serial_unit_if.slave bus
);
    localparam int W   = QI + QF;
    localparam int NIC = W / IW;
    localparam int NOC = W / OW;
    localparam int ICW = $clog2(NIC + 1);
    localparam int OCW = $clog2(NOC + 1);

    // 2^(2*QF) >> (W-1): the divider's starting remainder. The remaining low
    // dividend bits are all zero because 2*QF >= W-1.
    localparam logic [W-1:0]  REM_INIT     = {{(W-1){1'b0}}, 1'b1} << (2*QF - W + 1);
    localparam logic [63:0]   SAT_MAG_WIDE = sat_mag(W);
    localparam logic [W-1:0]  SAT_MAG      = SAT_MAG_WIDE[W-1:0];

    state_e         state_q, state_d;
    logic [W-1:0]   operand_q, operand_d;
    logic [ICW-1:0] icnt_q, icnt_d;
    logic [OCW-1:0] ocnt_q, ocnt_d;
    logic           abs_q, abs_d;
    logic           neg_q, neg_d;
    logic           sat_q, sat_d;
    logic [W-1:0]   res_q, res_d;

    logic           in_fire;
    logic           final_fire;
    logic [W-1:0]   opnd_next;
    logic [W-1:0]   mag_in;
    logic           sat_now;
    logic           div_done;
    logic [W-2:0]   div_quot;
    logic [W-1:0]   mag_out;
    logic [W-1:0]   res_next;

    // Operand assembly, magnitude and early saturation detection.
    // Saturation: q >= 2^(W-1) exactly when m <= 2^(2*QF) >> (W-1).
    always_comb begin
        in_fire    = (state_q == ST_LOAD) && bus.i_valid;
        final_fire = in_fire && (icnt_q == ICW'(NIC - 1));
        opnd_next  = (operand_q << IW) | {{(W-IW){1'b0}}, bus.i_data};
        mag_in     = opnd_next[W-1] ? (~opnd_next + 1'b1) : opnd_next;
        sat_now    = (mag_in == '0) || (mag_in <= REM_INIT);
    end

    recip_div_iter #(.W(W)) u_div (
        .clk           (clk),
        .reset         (reset),
        .start_i       (final_fire),
        .divisor_i     (mag_in),
        .rem_init_i    (REM_INIT),
        .dividend_lo_i ('0),
        .done_o        (div_done),
        .quot_o        (div_quot)
    );

    // Clamp and apply sign to the finished quotient.
    always_comb begin
        mag_out  = sat_q ? SAT_MAG : {1'b0, div_quot};
        res_next = (neg_q && !abs_q) ? (~mag_out + 1'b1) : mag_out;
    end

    // FSM next state: shift chunks in, wait for the divider, shift chunks out.
    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        icnt_d    = icnt_q;
        ocnt_d    = ocnt_q;
        abs_d     = abs_q;
        neg_d     = neg_q;
        sat_d     = sat_q;
        res_d     = res_q;
        case (state_q)
            ST_LOAD: begin
                if (in_fire) begin
                    operand_d = opnd_next;
                    icnt_d    = icnt_q + 1'b1;
                    if (final_fire) begin
                        icnt_d  = '0;
                        abs_d   = bus.i_abs;
                        neg_d   = opnd_next[W-1];
                        sat_d   = sat_now;
                        state_d = ST_DIVIDE;
                    end
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    res_d   = res_next;
                    ocnt_d  = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.i_ready) begin
                    res_d = res_q << OW;
                    if (ocnt_q == OCW'(NOC - 1)) begin
                        ocnt_d  = '0;
                        state_d = ST_LOAD;
                    end else begin
                        ocnt_d = ocnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // State registers; reset discards any in-flight work.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_LOAD;
            operand_q <= '0;
            icnt_q    <= '0;
            ocnt_q    <= '0;
            abs_q     <= 1'b0;
            neg_q     <= 1'b0;
            sat_q     <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            icnt_q    <= icnt_d;
            ocnt_q    <= ocnt_d;
            abs_q     <= abs_d;
            neg_q     <= neg_d;
            sat_q     <= sat_d;
            res_q     <= res_d;
        end
    end

    assign bus.o_ready = (state_q == ST_LOAD);
    assign bus.o_valid = (state_q == ST_SEND);
    assign bus.o_data  = res_q[W-1 -: OW];
    assign bus.o_last  = (state_q == ST_SEND) && (ocnt_q == OCW'(NOC - 1));
    assign bus.o_sat   = (state_q == ST_SEND) && sat_q;
    assign bus.o_busy  = (state_q != ST_LOAD);

endmodule
